// File: rtl/mdu_unit_if.sv
// CPU <-> multiply/divide unit bundle: command and operands in, HI/LO and status out.
interface mdu_unit_if #(
    parameter int DW = 32
);
    logic [2:0]    mdu;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          busy;
    logic          done;

    modport master (output mdu, rdata1, rdata2, input hi, lo, busy, done);
    modport slave  (input mdu, rdata1, rdata2, output hi, lo, busy, done);
endinterface

// File: rtl/mdu_unit.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply, restoring divide,
// single-cycle MTHI/MTLO. Signed ops run on magnitudes and are sign-corrected in a final FIX cycle.
module mdu_unit #(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic    clk,
    input  logic    rst_n,
    mdu_unit_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] C_MULT  = 3'd1;
    localparam logic [2:0] C_MULTU = 3'd2;
    localparam logic [2:0] C_DIV   = 3'd3;
    localparam logic [2:0] C_DIVU  = 3'd4;
    localparam logic [2:0] C_MTHI  = 3'd5;
    localparam logic [2:0] C_MTLO  = 3'd6;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             done_r;
    logic [DW-1:0]    hi_r, lo_r;

    // acc holds {partial product, multiplier} for MUL, {remainder, dividend/quotient} for DIV
    logic [2*DW:0]    acc;
    logic [DW-1:0]    opnd;
    logic             is_div, neg_q, neg_r, dz;

    logic             sgn_op, a_neg, b_neg;
    logic [DW-1:0]    mag_a, mag_b;
    logic [DW:0]      mul_sum, div_sh, div_diff;
    logic             div_ge;
    logic [2*DW-1:0]  prod;
    logic [DW-1:0]    fix_hi, fix_lo;

    function automatic logic [DW-1:0] mag_of(input logic [DW-1:0] x, input logic neg);
        return neg ? (~x + DW'(1)) : x;
    endfunction

    function automatic logic [2*DW-1:0] neg_wide(input logic [2*DW-1:0] x, input logic neg);
        return neg ? (~x + (2*DW)'(1)) : x;
    endfunction

    always_comb begin
        sgn_op   = (bus.mdu == C_MULT) || (bus.mdu == C_DIV);
        a_neg    = sgn_op & bus.rdata1[DW-1];
        b_neg    = sgn_op & bus.rdata2[DW-1];
        mag_a    = mag_of(bus.rdata1, a_neg);
        mag_b    = mag_of(bus.rdata2, b_neg);

        mul_sum  = acc[2*DW:DW] + {1'b0, (acc[0] ? opnd : {DW{1'b0}})};
        div_sh   = {acc[2*DW-1:DW], acc[DW-1]};
        div_diff = div_sh - {1'b0, opnd};
        div_ge   = div_sh >= {1'b0, opnd};

        prod     = neg_wide(acc[2*DW-1:0], neg_q);
        if (is_div) begin
            fix_lo = dz ? {DW{1'b1}} : mag_of(acc[DW-1:0], neg_q);
            fix_hi = mag_of(acc[2*DW-1:DW], neg_r);
        end else begin
            fix_hi = prod[2*DW-1:DW];
            fix_lo = prod[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    case (bus.mdu)
                        C_MULT, C_MULTU: begin state <= S_MUL; cnt <= '0; end
                        C_DIV, C_DIVU:   begin state <= S_DIV; cnt <= '0; end
                        C_MTHI:          hi_r <= bus.rdata1;
                        C_MTLO:          lo_r <= bus.rdata1;
                        default:         ;
                    endcase
                end
                S_MUL, S_DIV: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DW - 1)) state <= S_FIX;
                end
                default: begin
                    hi_r   <= fix_hi;
                    lo_r   <= fix_lo;
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath: operands latched on acceptance, one shift-add or restoring step per iteration
    always_ff @(posedge clk) begin
        if (state == S_IDLE) begin
            if (bus.mdu == C_MULT || bus.mdu == C_MULTU) begin
                acc    <= {{(DW+1){1'b0}}, mag_b};
                opnd   <= mag_a;
                neg_q  <= a_neg ^ b_neg;
                is_div <= 1'b0;
            end else if (bus.mdu == C_DIV || bus.mdu == C_DIVU) begin
                acc    <= {{(DW+1){1'b0}}, mag_a};
                opnd   <= mag_b;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                dz     <= (bus.rdata2 == '0);
                is_div <= 1'b1;
            end
        end else if (state == S_MUL) begin
            acc <= {1'b0, mul_sum, acc[DW-1:1]};
        end else if (state == S_DIV) begin
            acc <= {(div_ge ? div_diff : div_sh), acc[DW-2:0], div_ge};
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_r;
endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: spec vector table, random ops against an arithmetic model,
// and hand-written sequences for MTHI/MTLO timing, commands held while busy and async reset.
module tb_mdu_unit;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_unit_if #(.DW(32)) bus ();

    mdu_unit #(.DW(32), .CNT_W(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic on 64-bit integers; SV division truncates toward zero
    task automatic ref_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] eh, output logic [31:0] el);
        longint      sp, sa, sb, q, r;
        logic [63:0] up;
        eh = m_hi;
        el = m_lo;
        case (cmd)
            3'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                eh = sp[63:32];
                el = sp[31:0];
            end
            3'd2: begin
                up = {32'b0, a} * {32'b0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            3'd3: begin
                if (b == 0) begin
                    eh = a; el = '1;
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end
            end
            3'd4: begin
                if (b == 0) begin
                    eh = a; el = '1;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
            3'd5: eh = a;
            3'd6: el = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string tag);
        int n;
        @(negedge clk);
        bus.mdu = cmd; bus.rdata1 = a; bus.rdata2 = b;
        @(posedge clk); #1;
        bus.mdu = 3'd0; bus.rdata1 = $urandom; bus.rdata2 = $urandom;
        if (cmd == 3'd5 || cmd == 3'd6) begin
            check({tag, " busy"}, {31'b0, bus.busy}, 32'd0);
            check({tag, " done"}, {31'b0, bus.done}, 32'd0);
        end else begin
            check({tag, " hi held"}, bus.hi, m_hi);
            n = 0;
            while (bus.busy && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            check({tag, " busy cycles"}, n, 32'd33);
            check({tag, " done"}, {31'b0, bus.done}, 32'd1);
        end
        check({tag, " hi"}, bus.hi, eh);
        check({tag, " lo"}, bus.lo, el);
        if (cmd != 3'd5 && cmd != 3'd6) begin
            @(posedge clk); #1;
            check({tag, " done pulse end"}, {31'b0, bus.done}, 32'd0);
        end
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        logic [2:0]  cmd;
        logic [31:0] a, b, eh, el;
        int          n;

        vecs[0]  = '{3'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7"};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
        vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_m1m1"};
        vecs[3]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
        vecs[4]  = '{3'd4, 32'd7,        32'd2,        32'd1,        32'd3,        "divu_7_2"};
        vecs[5]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
        vecs[6]  = '{3'd4, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, "divu_by0"};
        vecs[7]  = '{3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, "div_5_by0"};
        vecs[8]  = '{3'd3, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div_m7_by0"};
        vecs[9]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minmin"};
        vecs[10] = '{3'd5, 32'h12345678, 32'd0,        32'h12345678, 32'h00000000, "mthi"};
        vecs[11] = '{3'd6, 32'h0000CAFE, 32'd0,        32'h12345678, 32'h0000CAFE, "mtlo"};

        bus.mdu = 3'd0; bus.rdata1 = '0; bus.rdata2 = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // No-op commands must leave everything untouched
        @(negedge clk); bus.mdu = 3'd7; bus.rdata1 = 32'h11111111;
        @(posedge clk); #1;
        check("noop7 busy", {31'b0, bus.busy}, 32'd0);
        check("noop7 hi", bus.hi, 32'd0);
        bus.mdu = 3'd0;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].name);

        for (int i = 0; i < 40; i++) begin
            cmd = 3'($urandom_range(1, 6));
            case ($urandom_range(0, 7))
                0:       a = 32'h80000000;
                1:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'h80000000;
                3:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            ref_op(cmd, a, b, eh, el);
            run_op(cmd, a, b, eh, el, $sformatf("rand%0d_c%0d", i, cmd));
        end

        // MTHI then MTLO on consecutive edges
        @(negedge clk); bus.mdu = 3'd5; bus.rdata1 = 32'h0000AAAA;
        @(posedge clk); #1;
        check("mthi_seq busy", {31'b0, bus.busy}, 32'd0);
        check("mthi_seq hi", bus.hi, 32'h0000AAAA);
        bus.mdu = 3'd6; bus.rdata1 = 32'h00005555;
        @(posedge clk); #1;
        check("mtlo_seq hi", bus.hi, 32'h0000AAAA);
        check("mtlo_seq lo", bus.lo, 32'h00005555);
        check("mtlo_seq busy", {31'b0, bus.busy}, 32'd0);
        bus.mdu = 3'd0;

        // MTHI held while a DIV is running is only taken once busy drops
        @(negedge clk); bus.mdu = 3'd3; bus.rdata1 = 32'd100; bus.rdata2 = 32'd7;
        @(posedge clk); #1;
        bus.mdu = 3'd5; bus.rdata1 = 32'h0000BEEF; bus.rdata2 = 32'd0;
        n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("held mthi latency", n, 32'd33);
        check("held mthi div hi", bus.hi, 32'd2);
        check("held mthi div lo", bus.lo, 32'd14);
        @(posedge clk); #1;
        check("held mthi hi", bus.hi, 32'h0000BEEF);
        check("held mthi lo", bus.lo, 32'd14);
        check("held mthi busy", {31'b0, bus.busy}, 32'd0);
        bus.mdu = 3'd0;

        // Async reset in the middle of a MULT
        @(negedge clk); bus.mdu = 3'd1; bus.rdata1 = 32'd7; bus.rdata2 = 32'd9;
        @(posedge clk); #1;
        bus.mdu = 3'd0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", {31'b0, bus.busy}, 32'd0);
        check("abort hi", bus.hi, 32'd0);
        check("abort lo", bus.lo, 32'd0);
        check("abort done", {31'b0, bus.done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        run_op(3'd2, 32'd3, 32'd5, 32'd0, 32'd15, "multu_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
